// File: rtl/serial_addsub6.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, LSB first,
// with a start/busy/done handshake that allows back-to-back operations.
module serial_addsub6 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic accept;
    logic last;
    logic sum_bit;
    logic carry_next;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last       = (cnt == CW'(WIDTH - 1));
    assign sum_bit    = a_sh[0] ^ b_sh[0] ^ cy;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: b is inverted on load and the carry is preloaded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            s         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            cy   <= sub;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= {sum_bit, s_sh[WIDTH-1:1]};
            cy   <= carry_next;
            cnt  <= cnt + CW'(1);
            // The visible result only changes on the final slice, so partial sums never leak.
            if (last) begin
                s         <= {sum_bit, s_sh[WIDTH-1:1]};
                carry_out <= carry_next;
                overflow  <= cy ^ carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub6.sv
// Self-checking bench for serial_addsub6: directed corner cases, reset abort,
// handshake behaviour, a full negation sweep and randomized operations.
module tb_serial_addsub6;

    localparam int WIDTH = 6;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             carry_out;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    serial_addsub6 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void refModel(input logic [5:0] ta, input logic [5:0] tb_v, input logic tsub,
                                     output logic [5:0] es, output logic eco, output logic eov);
        int ua, ub, full, sa, sb, sres;
        ua   = int'(ta);
        ub   = int'(tb_v);
        full = tsub ? (ua - ub + 64) : (ua + ub);
        es   = 6'(full % 64);
        eco  = (full >= 64);
        sa   = (ua >= 32) ? ua - 64 : ua;
        sb   = (ub >= 32) ? ub - 64 : ub;
        sres = tsub ? (sa - sb) : (sa + sb);
        eov  = (sres > 31) || (sres < -32);
    endfunction

    task automatic waitDone(input logic [5:0] hold_s, output int lat, output int hold_err);
        lat      = 0;
        hold_err = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (s !== hold_s) hold_err++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] ta, input logic [5:0] tb_v,
                                 input logic tsub);
        logic [5:0] es, prev;
        logic       eco, eov;
        int         lat, herr;
        refModel(ta, tb_v, tsub, es, eco, eov);
        @(negedge clk);
        prev  = s;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sub   = tsub;
        @(negedge clk);
        start = 1'b0;
        a     = 6'($urandom);
        b     = 6'($urandom);
        sub   = 1'($urandom);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
        waitDone(prev, lat, herr);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(WIDTH));
        checkOutput({tag, ".hold"}, 32'(herr), 32'd0);
        checkOutput({tag, ".s"}, 32'(s), 32'(es));
        checkOutput({tag, ".carry"}, 32'(carry_out), 32'(eco));
        checkOutput({tag, ".ovf"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        logic [5:0] es1, es2;
        logic       eco1, eov1, eco2, eov2;
        int         lat, herr, dcount;

        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.s", 32'(s), 32'd0);
        checkOutput("reset.carry", 32'(carry_out), 32'd0);
        checkOutput("reset.ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add_5_3", 6'b000101, 6'b000011, 1'b0);
        applyStimulus("sub_5_3", 6'b000101, 6'b000011, 1'b1);
        applyStimulus("sub_0_1", 6'b000000, 6'b000001, 1'b1);
        applyStimulus("add_31_1", 6'b011111, 6'b000001, 1'b0);
        applyStimulus("add_63_1", 6'b111111, 6'b000001, 1'b0);
        applyStimulus("sub_0_32", 6'b000000, 6'b100000, 1'b1);

        // start and operand changes during RUN are ignored
        refModel(6'd9, 6'd20, 1'b1, es1, eco1, eov1);
        @(negedge clk);
        start = 1'b1; a = 6'd9; b = 6'd20; sub = 1'b1;
        @(negedge clk);
        a = 6'd33; b = 6'd1; sub = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitDone(s, lat, herr);
        checkOutput("ignore.latency", 32'(lat), 32'd3);
        checkOutput("ignore.s", 32'(s), 32'(es1));
        checkOutput("ignore.carry", 32'(carry_out), 32'(eco1));
        checkOutput("ignore.ovf", 32'(overflow), 32'(eov1));

        // back-to-back: start held through the DONE cycle
        refModel(6'd10, 6'd7, 1'b0, es1, eco1, eov1);
        refModel(6'd21, 6'd34, 1'b1, es2, eco2, eov2);
        @(negedge clk);
        start = 1'b1; a = 6'd10; b = 6'd7; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waitDone(s, lat, herr);
        checkOutput("b2b.first_s", 32'(s), 32'(es1));
        start = 1'b1; a = 6'd21; b = 6'd34; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.busy", 32'(busy), 32'd1);
        waitDone(es1, lat, herr);
        checkOutput("b2b.spacing", 32'(lat + 1), 32'(WIDTH + 1));
        checkOutput("b2b.hold", 32'(herr), 32'd0);
        checkOutput("b2b.s", 32'(s), 32'(es2));
        checkOutput("b2b.carry", 32'(carry_out), 32'(eco2));
        checkOutput("b2b.ovf", 32'(overflow), 32'(eov2));

        // asynchronous reset in the third RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1; a = 6'b000101; b = 6'b000011; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.s", 32'(s), 32'd0);
        checkOutput("abort.carry", 32'(carry_out), 32'd0);
        checkOutput("abort.ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        checkOutput("abort.no_done", 32'(dcount), 32'd0);
        applyStimulus("abort.after", 6'b000101, 6'b000011, 1'b0);

        for (int i = 0; i < 64; i++) begin
            applyStimulus($sformatf("neg_%0d", i), 6'd0, 6'(i), 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rand_%0d", i), 6'($urandom), 6'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
